// File: rtl/pipe_mdu_ctrl_pkg.sv
// Shared constants and encodings for the multiply/divide sequencer.
package pipe_mdu_ctrl_pkg;

  // Operand width; one loop iteration is run per operand bit.
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  // md_op encodings. Bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_mdu_ctrl_iter_core.sv
// One combinational iteration of the shift-add multiplier or the
// restoring divider, operating on unsigned magnitudes.
//   multiply: upper = accumulator, lower = multiplier, operand = multiplicand
//   divide:   upper = remainder,   lower = quotient,   operand = divisor
module mdu_iter_core #(
  parameter int W = 32
) (
  input  logic         i_is_div,
  input  logic [W-1:0] i_upper,
  input  logic [W-1:0] i_lower,
  input  logic [W-1:0] i_operand,
  output logic [W-1:0] o_upper,
  output logic [W-1:0] o_lower
);

  logic [W:0]   w_sum;
  logic [W:0]   w_shl;
  logic         w_ge;
  logic [W-1:0] w_diff;

  // Multiply: conditionally add the multiplicand, keeping the carry so the
  // right shift of {carry, acc, multiplier} loses nothing.
  assign w_sum = {1'b0, i_upper} + (i_lower[0] ? {1'b0, i_operand} : {(W+1){1'b0}});

  // Divide: remainder shifted left with the next dividend bit. The remainder
  // is always below the divisor, so W+1 bits hold the shifted value and the
  // difference always fits back into W bits.
  assign w_shl  = {i_upper, i_lower[W-1]};
  assign w_ge   = (w_shl >= {1'b0, i_operand});
  assign w_diff = w_shl[W-1:0] - i_operand;

  // Select the next {upper, lower} pair for the active operation.
  always_comb begin
    o_upper = '0;
    o_lower = '0;
    if (i_is_div) begin
      o_upper = w_ge ? w_diff : w_shl[W-1:0];
      o_lower = {i_lower[W-2:0], w_ge};
    end else begin
      o_upper = w_sum[W:1];
      o_lower = {w_sum[0], i_lower[W-1:1]};
    end
  end

endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Multiply/divide sequencer beside EXE: runs a WIDTH-iteration loop on
// magnitudes, applies sign correction in FIX, owns HI/LO and raises the
// pipeline stall while an instruction needs the busy unit or HI/LO.
module pipe_mdu_ctrl
  import pipe_mdu_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] md_a,
  input  logic [WIDTH-1:0] md_b,
  input  logic             md_kill,
  input  logic             mf_req,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_upper;
  logic [WIDTH-1:0]   r_lower;
  logic [WIDTH-1:0]   r_operand;
  logic               r_is_div;
  logic               r_neg_q;   // negate product / quotient in FIX
  logic               r_neg_r;   // negate remainder in FIX
  logic               r_busy;

  logic               w_signed;
  logic               w_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic               w_last;
  logic [WIDTH-1:0]   w_next_upper;
  logic [WIDTH-1:0]   w_next_lower;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Operand decode and magnitudes, only meaningful in the start cycle.
  assign w_signed = ~md_op[0];
  assign w_div    = md_op[1];
  assign w_a_neg  = w_signed & md_a[WIDTH-1];
  assign w_b_neg  = w_signed & md_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (-md_a) : md_a;
  assign w_b_mag  = w_b_neg ? (-md_b) : md_b;
  assign w_b_zero = (md_b == '0);
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

  // Sign correction applied on the FIX edge. The 0x80000000 / -1 case needs
  // no special handling: its magnitude quotient negates back to itself.
  assign w_prod     = {r_upper, r_lower};
  assign w_prod_fix = r_neg_q ? (-w_prod) : w_prod;
  assign w_quot_fix = r_neg_q ? (-r_lower) : r_lower;
  assign w_rem_fix  = r_neg_r ? (-r_upper) : r_upper;

  mdu_iter_core #(
    .W (WIDTH)
  ) u_iter (
    .i_is_div  (r_is_div),
    .i_upper   (r_upper),
    .i_lower   (r_lower),
    .i_operand (r_operand),
    .o_upper   (w_next_upper),
    .o_lower   (w_next_lower)
  );

  // Sequencer FSM: operand capture, iteration, result write-back and MTHI/MTLO.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_upper   <= '0;
      r_lower   <= '0;
      r_operand <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!md_kill) begin
            if (md_start) begin
              r_is_div  <= w_div;
              r_operand <= w_b_mag;
              r_count   <= '0;
              r_busy    <= 1'b1;
              if (w_div && w_b_zero) begin
                // Divide by zero skips the loop: FIX writes lo=all ones, hi=md_a.
                r_upper <= md_a;
                r_lower <= '1;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_state <= S_FIX;
              end else begin
                r_upper <= '0;
                r_lower <= w_a_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_div & w_a_neg;
                r_state <= S_CALC;
              end
            end else begin
              if (mt_hi) r_hi <= mt_data;
              if (mt_lo) r_lo <= mt_data;
            end
          end
        end
        S_CALC: begin
          if (md_kill) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_upper <= w_next_upper;
            r_lower <= w_next_lower;
            r_count <= r_count + CNT_W'(1);
            if (w_last) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!md_kill) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quot_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = r_busy;
  // Combinational so the pipeline freezes in the same cycle as the request.
  assign stall = r_busy & (md_start | mf_req | mt_hi | mt_lo);

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Self-checking bench for pipe_mdu_ctrl: directed vector table, hand-written
// multi-cycle sequences, and random operations against an arithmetic model.
module tb_pipe_mdu_ctrl;
  import pipe_mdu_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_kill;
  logic        mf_req;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] mt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int n_total = 0;
  int n_pass  = 0;

  pipe_mdu_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .md_start(md_start),
    .md_op   (md_op),
    .md_a    (md_a),
    .md_b    (md_b),
    .md_kill (md_kill),
    .mf_req  (mf_req),
    .mt_hi   (mt_hi),
    .mt_lo   (mt_lo),
    .mt_data (mt_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic from the architectural definition.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, r, q64, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      MD_MULT:  r = sa * sb;
      MD_MULTU: r = ua * ub;
      MD_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else begin
          sq  = sa / sb;
          sr  = sa % sb;
          q64 = sq;
          r64 = sr;
          r   = {r64[31:0], q64[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else begin
          q64 = ua / ub;
          r64 = ua % ub;
          r   = {r64[31:0], q64[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Issue one operation, scramble the operand buses afterwards, and count
  // cycles with busy high (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    md_op    = op;
    md_a     = a;
    md_b     = b;
    md_start = 1'b1;
    step();
    md_start = 1'b0;
    md_a     = $urandom;
    md_b     = $urandom;
    cyc      = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      step();
    end
  endtask

  int          cyc;
  int          n;
  logic [1:0]  rop;
  logic [31:0] ra, rb;
  logic [63:0] exp64;

  initial begin
    reset = 1'b1; md_start = 0; md_op = 0; md_a = 0; md_b = 0; md_kill = 0;
    mf_req = 0; mt_hi = 0; mt_lo = 0; mt_data = 0;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[2] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[3] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[5] = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1};
    vecs[6] = '{MD_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1};

    // Reset state.
    step(); step();
    mf_req = 1'b1;
    #1;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_stall", stall, 0);
    mf_req = 1'b0;
    reset  = 1'b0;
    step();

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", i, vecs[i].op,
               vecs[i].a, vecs[i].b, hi, lo, cyc);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("vec%0d_busy_cycles", i), cyc, vecs[i].exp_cyc);
    end

    // mf_req three cycles after start: stall through FIX, result visible after.
    md_op = MD_MULTU; md_a = 3; md_b = 5; md_start = 1'b1;
    step();
    md_start = 1'b0;
    step(); step(); step();
    mf_req = 1'b1;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin n++; step(); end
    $display("mf_req stall_cycles=%0d hi=%h lo=%h", n, hi, lo);
    check("mf_stall_cycles", n, 30);
    check("mf_busy_after", busy, 0);
    check("mf_hi", hi, 0);
    check("mf_lo", lo, 15);
    mf_req = 1'b0;
    step();

    // Held md_start: second op accepted in the first IDLE cycle.
    md_op = MD_MULTU; md_a = 6; md_b = 7; md_start = 1'b1;
    step();
    md_a = 9; md_b = 9;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin n++; step(); end
    $display("held start stall_cycles=%0d hi=%h lo=%h", n, hi, lo);
    check("held_stall_cycles", n, 33);
    check("held_first_lo", lo, 42);
    check("held_idle_busy", busy, 0);
    step();
    md_start = 1'b0;
    check("held_second_busy", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; step(); end
    $display("held second busy_cycles=%0d hi=%h lo=%h", n, hi, lo);
    check("held_second_cycles", n, 33);
    check("held_second_lo", lo, 81);

    // MTHI in IDLE, then preload HI/LO.
    mt_hi = 1'b1; mt_data = 32'hABCD;
    step();
    mt_hi = 1'b0;
    $display("mthi hi=%h", hi);
    check("mthi_hi", hi, 32'hABCD);
    mt_hi = 1'b1; mt_data = 32'h11;
    step();
    mt_hi = 1'b0; mt_lo = 1'b1; mt_data = 32'h22;
    step();
    mt_lo = 1'b0;
    check("preload_hi", hi, 32'h11);
    check("preload_lo", lo, 32'h22);

    // Kill at count 10.
    md_op = MD_MULTU; md_a = 5; md_b = 5; md_start = 1'b1;
    step();
    md_start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    md_kill = 1'b1;
    step();
    md_kill = 1'b0;
    $display("kill calc busy=%b hi=%h lo=%h", busy, hi, lo);
    check("killcalc_busy", busy, 0);
    step();
    check("killcalc_hi", hi, 32'h11);
    check("killcalc_lo", lo, 32'h22);

    // Kill on the FIX edge.
    md_op = MD_MULTU; md_a = 5; md_b = 5; md_start = 1'b1;
    step();
    md_start = 1'b0;
    for (int k = 0; k < 32; k++) step();
    check("killfix_busy_before", busy, 1);
    md_kill = 1'b1;
    step();
    md_kill = 1'b0;
    check("killfix_busy", busy, 0);
    step();
    $display("kill fix busy=%b hi=%h lo=%h", busy, hi, lo);
    check("killfix_hi", hi, 32'h11);
    check("killfix_lo", lo, 32'h22);

    // Kill in IDLE suppresses start and MT writes.
    md_start = 1'b1; md_kill = 1'b1; mt_hi = 1'b1; mt_data = 32'h77;
    step();
    md_start = 1'b0; md_kill = 1'b0; mt_hi = 1'b0;
    check("killidle_busy", busy, 0);
    check("killidle_hi", hi, 32'h11);

    // md_start and MTLO together: start wins.
    md_op = MD_MULTU; md_a = 2; md_b = 3; md_start = 1'b1; mt_lo = 1'b1; mt_data = 32'h999;
    step();
    md_start = 1'b0; mt_lo = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; step(); end
    $display("start+mtlo hi=%h lo=%h", hi, lo);
    check("startwins_lo", lo, 6);
    check("startwins_hi", hi, 0);

    // MTLO while busy is held off, then written.
    md_op = MD_MULTU; md_a = 2; md_b = 2; md_start = 1'b1;
    step();
    md_start = 1'b0; mt_lo = 1'b1; mt_data = 32'h5555;
    #1;
    check("mtlo_busy_stall", stall, 1);
    n = 0;
    while (stall === 1'b1 && n < 100) begin n++; step(); end
    check("mtlo_result_lo", lo, 4);
    step();
    mt_lo = 1'b0;
    $display("mtlo held lo=%h", lo);
    check("mtlo_written", lo, 32'h5555);

    // Reset mid-CALC.
    md_op = MD_MULTU; md_a = 7; md_b = 7; md_start = 1'b1;
    step();
    md_start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    mf_req = 1'b1; reset = 1'b1;
    step();
    $display("reset mid-calc hi=%h lo=%h busy=%b stall=%b", hi, lo, busy, stall);
    check("rstcalc_hi", hi, 0);
    check("rstcalc_lo", lo, 0);
    check("rstcalc_busy", busy, 0);
    check("rstcalc_stall", stall, 0);
    reset = 1'b0; mf_req = 1'b0;
    step();

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2, 3:    rb = $urandom_range(1, 100);
        default: rb = $urandom;
      endcase
      exp64 = ref_md(rop, ra, rb);
      run_op(rop, ra, rb, cyc);
      $display("rand %0d op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", i, rop, ra, rb,
               hi, lo, cyc);
      check($sformatf("rand%0d_hi", i), hi, exp64[63:32]);
      check($sformatf("rand%0d_lo", i), lo, exp64[31:0]);
      check($sformatf("rand%0d_cycles", i), cyc, (rop[1] && rb == 32'd0) ? 1 : 33);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
